// File: rtl/ysyx_23060025_mem_arbiter.sv
// ysyx_23060025_mem_arbiter
//   Two-requester arbiter (icache refill, LSU) in front of the single downstream memory port.
//   One transaction is outstanding at a time. The payload is latched into registered mem_* outputs.
//   The response is routed combinationally to the owner.
//   A hung slave is aborted with an error after TIMEOUT_CYCLES busy cycles.
//   Optional feature macro: ARB_ROUND_ROBIN_EN.
//     Defined: round-robin on a simultaneous request.
//     Undefined: fixed priority, where the LSU wins.

module ysyx_23060025_mem_arbiter #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    icache_psel_i,
    input  logic [ADDR_WIDTH-1:0]   icache_paddr_i,
    output logic                    icache_pready_o,
    output logic [DATA_WIDTH-1:0]   icache_prdata_o,
    output logic                    icache_perr_o,
    input  logic                    lsu_psel_i,
    input  logic                    lsu_pwrite_i,
    input  logic [ADDR_WIDTH-1:0]   lsu_paddr_i,
    input  logic [DATA_WIDTH-1:0]   lsu_pwdata_i,
    input  logic [DATA_WIDTH/8-1:0] lsu_pstrb_i,
    output logic                    lsu_pready_o,
    output logic [DATA_WIDTH-1:0]   lsu_prdata_o,
    output logic                    lsu_perr_o,
    output logic                    mem_psel_o,
    output logic                    mem_pwrite_o,
    output logic [ADDR_WIDTH-1:0]   mem_paddr_o,
    output logic [DATA_WIDTH-1:0]   mem_pwdata_o,
    output logic [DATA_WIDTH/8-1:0] mem_pstrb_o,
    input  logic                    mem_pready_i,
    input  logic [DATA_WIDTH-1:0]   mem_prdata_i,
    input  logic                    mem_perr_i,
    output logic                    arb_busy_o
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);
    localparam logic [CntW-1:0] CntMax  = CntW'(TIMEOUT_CYCLES);

    typedef enum logic {
        StIdle,
        StBusy
    } state_e;

    state_e          state;
    logic            owner;       // 0 = icache, 1 = LSU
    logic            last_owner;
    logic [CntW-1:0] to_cnt;

    logic any_req;
    logic grant_lsu;
    logic timeout_hit;
    logic done;
    logic resp_fire;

    assign any_req     = icache_psel_i | lsu_psel_i;
    assign timeout_hit = (state == StBusy) && !mem_pready_i && (to_cnt == CntLast);
    assign done        = (state == StBusy) && (mem_pready_i || timeout_hit);
    // A reset cycle abandons the transaction, so no pulse escapes even if the slave answers.
    assign resp_fire   = done && !reset;
    assign arb_busy_o  = (state == StBusy);

`ifdef ARB_ROUND_ROBIN_EN
    // On a tie, the requester that did not own the previous transaction wins.
    assign grant_lsu = lsu_psel_i && (!icache_psel_i || !last_owner);
`else
    assign grant_lsu = lsu_psel_i;
    logic unused_last_owner;
    assign unused_last_owner = last_owner;
`endif

    // Route the completion (or a timeout abort) to the current owner only.
    always_comb begin
        icache_pready_o = 1'b0;
        icache_prdata_o = '0;
        icache_perr_o   = 1'b0;
        lsu_pready_o    = 1'b0;
        lsu_prdata_o    = '0;
        lsu_perr_o      = 1'b0;
        if (resp_fire) begin
            if (owner) begin
                lsu_pready_o = 1'b1;
                lsu_prdata_o = mem_pready_i ? mem_prdata_i : '0;
                lsu_perr_o   = mem_pready_i ? mem_perr_i : 1'b1;
            end else begin
                icache_pready_o = 1'b1;
                icache_prdata_o = mem_pready_i ? mem_prdata_i : '0;
                icache_perr_o   = mem_pready_i ? mem_perr_i : 1'b1;
            end
        end
    end

    // Arbitration FSM with registered downstream request and timeout counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= StIdle;
            owner        <= 1'b0;
            last_owner   <= 1'b0;
            to_cnt       <= '0;
            mem_psel_o   <= 1'b0;
            mem_pwrite_o <= 1'b0;
            mem_paddr_o  <= '0;
            mem_pwdata_o <= '0;
            mem_pstrb_o  <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    to_cnt <= '0;
                    if (any_req) begin
                        state      <= StBusy;
                        owner      <= grant_lsu;
                        mem_psel_o <= 1'b1;
                        if (grant_lsu) begin
                            mem_pwrite_o <= lsu_pwrite_i;
                            mem_paddr_o  <= lsu_paddr_i;
                            mem_pwdata_o <= lsu_pwdata_i;
                            mem_pstrb_o  <= lsu_pstrb_i;
                        end else begin
                            mem_pwrite_o <= 1'b0;
                            mem_paddr_o  <= icache_paddr_i;
                            mem_pwdata_o <= '0;
                            mem_pstrb_o  <= '0;
                        end
                    end
                end
                StBusy: begin
                    if (done) begin
                        state        <= StIdle;
                        last_owner   <= owner;
                        to_cnt       <= '0;
                        mem_psel_o   <= 1'b0;
                        mem_pwrite_o <= 1'b0;
                        mem_paddr_o  <= '0;
                        mem_pwdata_o <= '0;
                        mem_pstrb_o  <= '0;
                    end else if (to_cnt != CntMax) begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_23060025_mem_arbiter.sv
// Self-checking bench for ysyx_23060025_mem_arbiter.
// Each issued request pushes its expected response to a scoreboard queue.
// A negedge monitor pops and compares every response pulse.

module tb_ysyx_23060025_mem_arbiter;

    localparam int TO = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        icache_psel_i = 1'b0;
    logic [31:0] icache_paddr_i = '0;
    logic        icache_pready_o;
    logic [31:0] icache_prdata_o;
    logic        icache_perr_o;
    logic        lsu_psel_i = 1'b0;
    logic        lsu_pwrite_i = 1'b0;
    logic [31:0] lsu_paddr_i = '0;
    logic [31:0] lsu_pwdata_i = '0;
    logic [3:0]  lsu_pstrb_i = '0;
    logic        lsu_pready_o;
    logic [31:0] lsu_prdata_o;
    logic        lsu_perr_o;
    logic        mem_psel_o;
    logic        mem_pwrite_o;
    logic [31:0] mem_paddr_o;
    logic [31:0] mem_pwdata_o;
    logic [3:0]  mem_pstrb_o;
    logic        mem_pready_i = 1'b0;
    logic [31:0] mem_prdata_i = '0;
    logic        mem_perr_i = 1'b0;
    logic        arb_busy_o;

    ysyx_23060025_mem_arbiter #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .icache_psel_i  (icache_psel_i),
        .icache_paddr_i (icache_paddr_i),
        .icache_pready_o(icache_pready_o),
        .icache_prdata_o(icache_prdata_o),
        .icache_perr_o  (icache_perr_o),
        .lsu_psel_i     (lsu_psel_i),
        .lsu_pwrite_i   (lsu_pwrite_i),
        .lsu_paddr_i    (lsu_paddr_i),
        .lsu_pwdata_i   (lsu_pwdata_i),
        .lsu_pstrb_i    (lsu_pstrb_i),
        .lsu_pready_o   (lsu_pready_o),
        .lsu_prdata_o   (lsu_prdata_o),
        .lsu_perr_o     (lsu_perr_o),
        .mem_psel_o     (mem_psel_o),
        .mem_pwrite_o   (mem_pwrite_o),
        .mem_paddr_o    (mem_paddr_o),
        .mem_pwdata_o   (mem_pwdata_o),
        .mem_pstrb_o    (mem_pstrb_o),
        .mem_pready_i   (mem_pready_i),
        .mem_prdata_i   (mem_prdata_i),
        .mem_perr_i     (mem_perr_i),
        .arb_busy_o     (arb_busy_o)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        lsu;
        logic [31:0] data;
        logic        err;
    } exp_t;

    typedef struct {
        bit          lsu;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          wt;        // BUSY cycle index at which the slave answers
        logic [31:0] rdata;
        bit          rerr;
        logic [31:0] exp_data;
        bit          exp_err;
    } vec_t;

    exp_t sb[$];
    int   n_run = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Response monitor: every pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (icache_pready_o || lsu_pready_o) begin
            exp_t e;
            check("one_pulse_only", 32'(icache_pready_o & lsu_pready_o), 32'd0);
            check("pulse_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("resp_owner", 32'(lsu_pready_o), 32'(e.lsu));
                check("resp_data", e.lsu ? lsu_prdata_o : icache_prdata_o, e.data);
                check("resp_err", 32'(e.lsu ? lsu_perr_o : icache_perr_o), 32'(e.err));
                check("non_owner_quiet",
                      e.lsu ? (icache_prdata_o | 32'(icache_perr_o))
                            : (lsu_prdata_o | 32'(lsu_perr_o)), 32'd0);
            end
        end
    end

    task automatic do_reset();
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    // Single request through a programmable-latency slave, with payload scrambling while busy.
    task automatic run_vec(input vec_t v, input string tag);
        int last;
        last = (v.wt < TO) ? v.wt : TO - 1;
        @(posedge clock); #1;
        check({tag, "_idle_psel"}, 32'(mem_psel_o), 32'd0);
        if (v.lsu) begin
            lsu_psel_i     = 1'b1;
            lsu_pwrite_i   = v.wr;
            lsu_paddr_i    = v.addr;
            lsu_pwdata_i   = v.wdata;
            lsu_pstrb_i    = v.strb;
            icache_paddr_i = 32'h0bad_0000;
        end else begin
            icache_psel_i  = 1'b1;
            icache_paddr_i = v.addr;
            lsu_paddr_i    = 32'h0bad_0001;
            lsu_pwrite_i   = 1'b1;
            lsu_pstrb_i    = 4'hf;
        end
        sb.push_back('{v.lsu, v.exp_data, v.exp_err});
        @(posedge clock); #1;
        check({tag, "_psel"}, 32'(mem_psel_o), 32'd1);
        check({tag, "_busy"}, 32'(arb_busy_o), 32'd1);
        check({tag, "_paddr"}, mem_paddr_o, v.addr);
        check({tag, "_pwrite"}, 32'(mem_pwrite_o), v.lsu ? 32'(v.wr) : 32'd0);
        check({tag, "_pstrb"}, 32'(mem_pstrb_o), v.lsu ? 32'(v.strb) : 32'd0);
        if (v.lsu && v.wr) check({tag, "_pwdata"}, mem_pwdata_o, v.wdata);
        icache_psel_i  = 1'b0;
        lsu_psel_i     = 1'b0;
        icache_paddr_i = ~v.addr;
        lsu_paddr_i    = ~v.addr;
        lsu_pwdata_i   = ~v.wdata;
        lsu_pwrite_i   = ~v.wr;
        for (int k = 0; k <= last; k++) begin
            mem_pready_i = (k == v.wt);
            mem_prdata_i = v.rdata;
            mem_perr_i   = v.rerr;
            if (k == last) check({tag, "_paddr_held"}, mem_paddr_o, v.addr);
            @(posedge clock); #1;
            check({tag, "_pending"}, sb.size(), (k == last) ? 32'd0 : 32'd1);
        end
        mem_pready_i = 1'b0;
        mem_perr_i   = 1'b0;
        check({tag, "_psel_drop"}, 32'(mem_psel_o), 32'd0);
        check({tag, "_busy_drop"}, 32'(arb_busy_o), 32'd0);
        check({tag, "_pwrite_clr"}, 32'(mem_pwrite_o), 32'd0);
        check({tag, "_pstrb_clr"}, 32'(mem_pstrb_o), 32'd0);
    endtask

    // Both request together and hold; each drops after its own response.
    task automatic both_req(input bit first_lsu, input string tag);
        @(posedge clock); #1;
        icache_psel_i  = 1'b1;
        icache_paddr_i = 32'h3000_0040;
        lsu_psel_i     = 1'b1;
        lsu_pwrite_i   = 1'b0;
        lsu_paddr_i    = 32'h8000_0100;
        lsu_pwdata_i   = '0;
        lsu_pstrb_i    = '0;
        for (int g = 0; g < 2; g++) begin
            bit is_lsu;
            is_lsu = (g == 0) ? first_lsu : !first_lsu;
            sb.push_back('{is_lsu, is_lsu ? 32'h1111_0001 : 32'h2222_0002, 1'b0});
            @(posedge clock); #1;
            check({tag, "_grant_addr"}, mem_paddr_o, is_lsu ? 32'h8000_0100 : 32'h3000_0040);
            check({tag, "_grant_busy"}, 32'(arb_busy_o), 32'd1);
            mem_pready_i = 1'b1;
            mem_prdata_i = is_lsu ? 32'h1111_0001 : 32'h2222_0002;
            mem_perr_i   = 1'b0;
            @(posedge clock); #1;
            mem_pready_i = 1'b0;
            check({tag, "_served"}, sb.size(), 32'd0);
            check({tag, "_bubble"}, 32'(mem_psel_o), 32'd0);
            if (is_lsu) lsu_psel_i = 1'b0;
            else icache_psel_i = 1'b0;
        end
    endtask

    vec_t vecs[6];

    initial begin
        //       lsu  wr    addr           wdata          strb    wt  rdata          rerr  exp_data       exp_err
        vecs[0] = '{1'b0, 1'b0, 32'h3000_0000, 32'h0,         4'h0,   3, 32'h0000_0413, 1'b0, 32'h0000_0413, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'h3,   0, 32'h0,         1'b0, 32'h0,         1'b0};
        vecs[2] = '{1'b1, 1'b0, 32'h8000_0020, 32'h0,         4'hf,   1, 32'hCAFE_F00D, 1'b1, 32'hCAFE_F00D, 1'b1};
        vecs[3] = '{1'b0, 1'b0, 32'h3000_0100, 32'h0,         4'h0,  20, 32'h1234_5678, 1'b0, 32'h0,         1'b1};
        vecs[4] = '{1'b1, 1'b0, 32'h8000_0030, 32'h0,         4'hf,   7, 32'h5555_AAAA, 1'b0, 32'h5555_AAAA, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 32'h8000_0040, 32'h0102_0304, 4'hc,   8, 32'h7777_7777, 1'b0, 32'h0,         1'b1};

        // Reset values
        @(posedge clock); #1;
        @(posedge clock); #1;
        check("rst_mem_psel", 32'(mem_psel_o), 32'd0);
        check("rst_mem_pwrite", 32'(mem_pwrite_o), 32'd0);
        check("rst_mem_paddr", mem_paddr_o, 32'd0);
        check("rst_mem_pwdata", mem_pwdata_o, 32'd0);
        check("rst_mem_pstrb", 32'(mem_pstrb_o), 32'd0);
        check("rst_resp", icache_prdata_o | lsu_prdata_o
              | 32'({icache_pready_o, icache_perr_o, lsu_pready_o, lsu_perr_o}), 32'd0);
        check("rst_busy", 32'(arb_busy_o), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Simultaneous requests from reset: LSU first in both modes
        do_reset();
        both_req(1'b1, "tie_from_reset");
        // After an LSU-only transaction, round-robin favours the icache
        run_vec(vecs[2], "lsu_only");
`ifdef ARB_ROUND_ROBIN_EN
        both_req(1'b0, "tie_after_lsu");
`else
        both_req(1'b1, "tie_after_lsu");
`endif

        // Reset two cycles into BUSY abandons the transaction silently
        @(posedge clock); #1;
        icache_psel_i  = 1'b1;
        icache_paddr_i = 32'h3000_0080;
        @(posedge clock); #1;
        icache_psel_i = 1'b0;
        check("abort_busy", 32'(arb_busy_o), 32'd1);
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("abort_psel", 32'(mem_psel_o), 32'd0);
        check("abort_idle", 32'(arb_busy_o), 32'd0);
        mem_pready_i = 1'b1;   // stray completion while idle must be ignored
        @(posedge clock); #1;
        mem_pready_i = 1'b0;
        check("abort_no_grant", 32'(mem_psel_o), 32'd0);
        run_vec(vecs[0], "after_abort");

        @(posedge clock); #1;
        check("sb_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
